// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences Load then N Shift_En pulses at a programmed rate for the 32-bit shift register.
// Latency: Load the cycle after accept; first Shift_En div+1 cycles after Load; Done the cycle after the last Shift_En.
// Backpressure: Start_Ready is high only in IDLE; requests outside IDLE are ignored. Optional abort: SHIFT_SEQ_ABORT_EN.
module shift_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6,
    parameter int DIV_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start_Valid,
    output logic             Start_Ready,
    input  logic [CNT_W-1:0] Shift_Count,
    input  logic [DIV_W-1:0] Div,
    output logic             Load,
    output logic             Shift_En,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Bit_Idx
`ifdef SHIFT_SEQ_ABORT_EN
    ,
    input  logic             Abort,
    output logic             Aborted
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    state_t             state_q,       state_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [DIV_W-1:0]   div_q,         div_d;
    logic [DIV_W-1:0]   div_cnt_q,     div_cnt_d;
    logic [CNT_W-1:0]   bit_idx_q,     bit_idx_d;
    logic               load_q,        load_d;
    logic               shift_en_q,    shift_en_d;
    logic               busy_q,        busy_d;
    logic               done_q,        done_d;
    logic               start_ready_q, start_ready_d;
    logic               aborted_q,     aborted_d;

    // Next-state and registered-output logic; outputs are decoded from the next state so they appear
    // in the same cycle the state is entered. div_cnt holds the divider value of the current cycle and
    // a Shift_En pulse is scheduled for every cycle in which it reads zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_en_d = 1'b0;
        aborted_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start_Valid && start_ready_q) begin
                    // zero and anything above WIDTH both mean a full-width transfer
                    cnt_d     = (Shift_Count == '0 || Shift_Count > WIDTH_C) ? WIDTH_C : Shift_Count;
                    div_d     = Div;
                    bit_idx_d = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d    = ST_SHIFT;
                div_cnt_d  = div_q;
                shift_en_d = (div_q == '0);
            end
            ST_SHIFT: begin
                if (shift_en_q && bit_idx_q == cnt_q) begin
                    state_d = ST_DONE;
                end else begin
                    div_cnt_d  = (div_cnt_q == '0) ? div_q : div_cnt_q - 1'b1;
                    shift_en_d = (div_cnt_d == '0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (shift_en_d) begin
            bit_idx_d = bit_idx_q + 1'b1;
        end

`ifdef SHIFT_SEQ_ABORT_EN
        // abort only cuts an active transfer; the pulse it would have scheduled is dropped
        if (Abort && (state_q == ST_LOAD || state_q == ST_SHIFT)) begin
            state_d    = ST_IDLE;
            shift_en_d = 1'b0;
            bit_idx_d  = bit_idx_q;
            aborted_d  = 1'b1;
        end
`endif

        load_d        = (state_d == ST_LOAD);
        done_d        = (state_d == ST_DONE);
        busy_d        = (state_d != ST_IDLE);
        start_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset; Start_Ready stays low through the reset cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            div_q         <= '0;
            div_cnt_q     <= '0;
            bit_idx_q     <= '0;
            load_q        <= 1'b0;
            shift_en_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            start_ready_q <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            div_cnt_q     <= div_cnt_d;
            bit_idx_q     <= bit_idx_d;
            load_q        <= load_d;
            shift_en_q    <= shift_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            start_ready_q <= start_ready_d;
            aborted_q     <= aborted_d;
        end
    end

    assign Start_Ready = start_ready_q;
    assign Load        = load_q;
    assign Shift_En    = shift_en_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Bit_Idx     = bit_idx_q;

`ifdef SHIFT_SEQ_ABORT_EN
    assign Aborted = aborted_q;
`else
    // without the abort port the flag can never be raised
    logic unused_aborted;
    assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: reset, timed transfers, count clamping, held request, mid-transfer reset/abort.
// Cycle numbering: accept at edge T, the value sampled 1 time unit after edge T+k-1 is "cycle T+k".
// All waits are bounded; an expired bound is reported as a failed comparison.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic [5:0] shift_count;
    logic [7:0] div;
    logic       load;
    logic       shift_en;
    logic       busy;
    logic       done;
    logic [5:0] bit_idx;
`ifdef SHIFT_SEQ_ABORT_EN
    logic       abort_in;
    logic       aborted;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl dut (
        .Clk         (clk),
        .Reset       (rst),
        .Start_Valid (start_valid),
        .Start_Ready (start_ready),
        .Shift_Count (shift_count),
        .Div         (div),
        .Load        (load),
        .Shift_En    (shift_en),
        .Busy        (busy),
        .Done        (done),
        .Bit_Idx     (bit_idx)
`ifdef SHIFT_SEQ_ABORT_EN
        ,
        .Abort       (abort_in),
        .Aborted     (aborted)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer: accept at the next edge, then trace cycles T+1 .. T+done_exp+1.
    task automatic xfer(input string tag, input int cnt, input int dv, input int n_exp, input int done_exp);
        int   waited;
        int   first;
        int   loads;
        int   load1;
        int   pulses;
        int   bad_pat;
        int   overlap;
        int   done_at;
        int   dones;
        int   rdy_bad;
        logic exp_se;
        waited  = 0;
        first   = 2 + dv;
        loads   = 0;
        load1   = 0;
        pulses  = 0;
        bad_pat = 0;
        overlap = 0;
        done_at = -1;
        dones   = 0;
        rdy_bad = 0;
        while (start_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        chk($sformatf("%s_ready_before", tag), start_ready, 1);
        start_valid = 1'b1;
        shift_count = cnt[5:0];
        div         = dv[7:0];
        tick();
        // changes after accept must not disturb the transfer
        start_valid = 1'b0;
        shift_count = 6'd7;
        div         = 8'd3;
        for (int k = 1; k <= done_exp + 1; k++) begin
            if (k > 1) tick();
            exp_se = (k >= first) && (((k - first) % (dv + 1)) == 0) && (((k - first) / (dv + 1)) < n_exp);
            if (shift_en !== exp_se) bad_pat++;
            if (shift_en === 1'b1) pulses++;
            if (load === 1'b1) begin
                loads++;
                if (k == 1) load1 = 1;
            end
            if (load === 1'b1 && shift_en === 1'b1) overlap++;
            if (done === 1'b1) begin
                dones++;
                done_at = k;
            end
            if (k <= done_exp && start_ready !== 1'b0) rdy_bad++;
        end
        chk($sformatf("%s_load_at_T+1", tag), load1, 1);
        chk($sformatf("%s_load_count", tag), loads, 1);
        chk($sformatf("%s_shift_pulses", tag), pulses, n_exp);
        chk($sformatf("%s_shift_timing_errs", tag), bad_pat, 0);
        chk($sformatf("%s_load_shift_overlap", tag), overlap, 0);
        chk($sformatf("%s_done_cycle", tag), done_at, done_exp);
        chk($sformatf("%s_done_count", tag), dones, 1);
        chk($sformatf("%s_ready_while_busy", tag), rdy_bad, 0);
        chk($sformatf("%s_ready_after_done", tag), start_ready, 1);
        chk($sformatf("%s_busy_after_done", tag), busy, 0);
        chk($sformatf("%s_bit_idx", tag), bit_idx, n_exp);
    endtask

    initial begin
        int loads;
        int last_load;
        int bad_gap;
        int bad_acc;
        int prev_ok;
        int found;
        int cnt_se;
        int cnt_done;
        int waited;
        int cnt_ab;

        rst         = 1'b1;
        start_valid = 1'b0;
        shift_count = 6'd0;
        div         = 8'd0;
`ifdef SHIFT_SEQ_ABORT_EN
        abort_in    = 1'b0;
`endif

        // reset held two cycles
        tick();
        tick();
        chk("rst_load", load, 0);
        chk("rst_shift_en", shift_en, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bit_idx", bit_idx, 0);
        chk("rst_ready_low", start_ready, 0);
        rst = 1'b0;
        tick();
        chk("rst_ready_next", start_ready, 1);

        // tag, cnt, div, pulses, Done cycle (T+2+div first, div+1 spacing, Done one after last)
        xfer("c4d0",  4, 0,  4,  6);
        xfer("c3d2",  3, 2,  3, 11);
        xfer("c0d0",  0, 0, 32, 34);
        xfer("c40d0", 40, 0, 32, 34);
        xfer("c1d5",  1, 5,  1,  8);
        xfer("c33d1", 33, 1, 32, 66);

        // request held high, cnt=2 div=0: Load T+1, Shift T+2..T+3, Done T+4, Ready T+5,
        // next accept at edge T+5, so Load repeats every 5 sampled cycles: k = 1,6,11,16,21,26
        start_valid = 1'b1;
        shift_count = 6'd2;
        div         = 8'd0;
        loads       = 0;
        last_load   = -1;
        bad_gap     = 0;
        bad_acc     = 0;
        prev_ok     = (start_ready === 1'b1 && busy === 1'b0) ? 1 : 0;
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (load === 1'b1) begin
                loads++;
                if (prev_ok == 0) bad_acc++;
                if (last_load >= 0 && (k - last_load) != 5) bad_gap++;
                last_load = k;
            end
            prev_ok = (start_ready === 1'b1 && busy === 1'b0) ? 1 : 0;
        end
        start_valid = 1'b0;
        chk("held_accepts", loads, 6);
        chk("held_gap_errs", bad_gap, 0);
        chk("held_accept_while_busy", bad_acc, 0);
        waited = 0;
        while (start_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        chk("held_drain_ready", start_ready, 1);

        // reset at the 2nd Shift_En of a cnt=8 transfer
        start_valid = 1'b1;
        shift_count = 6'd8;
        div         = 8'd0;
        tick();
        start_valid = 1'b0;
        found  = 0;
        waited = 0;
        while (found == 0 && waited < 20) begin
            tick();
            waited++;
            if (shift_en === 1'b1 && bit_idx == 6'd2) found = 1;
        end
        chk("midrst_found_2nd_shift", found, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_shift_en", shift_en, 0);
        chk("midrst_bit_idx", bit_idx, 0);
        cnt_se   = 0;
        cnt_done = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (shift_en === 1'b1) cnt_se++;
            if (done === 1'b1) cnt_done++;
        end
        chk("midrst_no_shift", cnt_se, 0);
        chk("midrst_no_done", cnt_done, 0);
        chk("midrst_ready", start_ready, 1);

`ifdef SHIFT_SEQ_ABORT_EN
        // abort in IDLE is ignored
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        chk("abort_idle_ignored", aborted, 0);
        chk("abort_idle_ready", start_ready, 1);

        // abort at the 2nd Shift_En of a cnt=8 transfer
        start_valid = 1'b1;
        shift_count = 6'd8;
        div         = 8'd0;
        tick();
        start_valid = 1'b0;
        found  = 0;
        waited = 0;
        while (found == 0 && waited < 20) begin
            tick();
            waited++;
            if (shift_en === 1'b1 && bit_idx == 6'd2) found = 1;
        end
        chk("abort_found_2nd_shift", found, 1);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        chk("abort_pulse", aborted, 1);
        chk("abort_busy", busy, 0);
        chk("abort_shift_en", shift_en, 0);
        cnt_se   = 0;
        cnt_done = 0;
        cnt_ab   = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (shift_en === 1'b1) cnt_se++;
            if (done === 1'b1) cnt_done++;
            if (aborted === 1'b1) cnt_ab++;
        end
        chk("abort_no_shift", cnt_se, 0);
        chk("abort_no_done", cnt_done, 0);
        chk("abort_single_pulse", cnt_ab, 0);
        chk("abort_ready", start_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
